tmp10x_i2c_target: RTL and testbench
====================================

// Module: tmp10x_i2c_target
// PURPOSE
//  Clocked I2C target (responder) emulating a TMP100/TMP101 register file, answering the existing I2C master.
//  Oversamples SCL/SDA on Clk, decodes START/STOP/address/pointer, serves temperature, config, TLOW and THIGH.
//  Sits on the shared open-drain SDA/SCL pair (pullups at board/bench level); temperature comes from a sensor-side port.
// PARAMETERS
//  ADDRESS    7'h48  7-bit target address matched against first byte [7:1]; bit 0 = R/W (1 = read)
//  TLOW_RST  16'h4B00  TLOW reset value (75 C, 12-bit left-justified)
//  THIGH_RST 16'h5000  THIGH reset value (80 C)
// PORTS
//  Clk          in     1   system clock; must be >= 8x SCL frequency
//  RST          in     1   asynchronous reset, active low
//  SCL          in     1   I2C clock (target never stretches)
//  SDA          inout  1   I2C data, open drain: drives 1'b0 or 1'bz only
//  Temperature  in    12   signed temperature, 0.0625 C/LSB
//  TempValid    in     1   1-cycle strobe: load Temperature into temp register
//  Config       out    8   current configuration register
//  Busy         out    1   1 from address match until STOP/START/NACK release
//  Alert        out    1   thermostat output (see CONFIGURATION)
// BEHAVIOUR
//  Reset: SDA=z, Busy=0, Config=8'h00, TLOW/THIGH=*_RST, temp=0, pointer=0, state IDLE; applies immediately mid-transfer.
//  Inputs: SCL/SDA via 2-FF sync; edges from sync'd values. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  SDA sampled on sync'd SCL rise; SDA drive changes only 1 Clk after sync'd SCL fall.
//  FSM: IDLE -START-> ADDR(8 bits) -> ADDR_ACK (drive 0 for 9th bit if match, else IGNORE)
//   write: PTR(8) -> PTR_ACK -> WDATA(8) -> WDATA_ACK -> WDATA ...
//   read:  RDATA(8, MSB first) -> MACK (sample master bit 9): ACK -> RDATA next byte; NACK -> IGNORE (SDA released)
//   IGNORE: SDA=z until START/STOP. START in any state -> ADDR (repeated start). STOP in any state -> IDLE.
//  Pointer: byte[1:0] selects 0=TEMP(RO) 1=CONFIG 2=TLOW 3=THIGH; bits [7:2] ignored; persists across transactions.
//  Byte index cleared on every ADDR_ACK. 2-byte regs: MSB then LSB, index toggles (3rd byte = MSB again).
//  CONFIG is 1 byte: every read byte returns Config; every written byte overwrites Config.
//  TEMP read value = {temp[11:0],4'b0}; shadow copied at ADDR_ACK of a read so MSB/LSB never tear.
//  Writes to TEMP ACKed and discarded. TLOW/THIGH writes: MSB latched, register updated on LSB ACK; low nibble forced 0.
//  TempValid ignored when Config[0] (SD) = 1; TempValid coincident with a read only updates live temp, not shadow.
//  Every byte after a matched address is ACKed; no NACK-on-overflow.
//  Busy=1 from matched ADDR_ACK to IDLE/IGNORE; Busy=0 in IGNORE after mismatch.
// CONFIGURATION
//  Macro TMP10X_ALERT_EN defined: comparator thermostat; active level per Config[2] (POL, 0=active low).
//   Asserts the cycle after temp >= THIGH[15:4] (signed); deasserts when temp < TLOW[15:4]; holds in between.
//   Reset: inactive (1 when POL=0).
//  Undefined: Alert tied 1'b1; Config[2] stored/readable with no effect.
// STRUCTURE
//  Package tmp10x_pkg: pointer codes (PTR_TEMP..PTR_THIGH), FSM state encoding, Config bit indices (SD=0, POL=2).
//  Sub-module i2c_bus_sync: 2-FF sync of SCL/SDA, scl_rise/scl_fall/start_det/stop_det pulses.
// TESTING
//  Write ptr: START,0x90,0x01,0x60,STOP -> 3 ACKs, Config=8'h60.
//  Read temp: TempValid Temperature=12'h190, write ptr 0, Sr, 0x91, master ACK/NACK -> bytes 0x19,0x00; SDA z after NACK.
//  THIGH write: 0x90,0x03,0x55,0xA7 -> read back 0x55,0xA0; extra 3rd read byte = 0x55.
//  Wrong address 0x92 -> no ACK (SDA z at bit 9), Busy=0, registers unchanged, next START to 0x90 ACKed.
//  RST low mid-RDATA with SDA driven 0 -> SDA z immediately, Config=0, THIGH=16'h5000.
//  TMP10X_ALERT_EN: temp 12'h500 -> Alert=0; 12'h4C0 -> stays 0; 12'h4A0 -> Alert=1; Config[2]=1 inverts.

Source files
------------

// File: rtl/tmp10x_pkg.sv
// rtl/tmp10x_pkg.sv - TMP100/TMP101 target shared types: pointer codes, FSM states, config bits, read mux
package tmp10x_pkg;

    typedef enum logic [1:0] {
        PTR_TEMP   = 2'd0,
        PTR_CONFIG = 2'd1,
        PTR_TLOW   = 2'd2,
        PTR_THIGH  = 2'd3
    } ptr_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_MACK,
        ST_IGNORE
    } state_e;

    localparam int CFG_SD  = 0;
    localparam int CFG_POL = 2;

    // idx 0 selects the MSB of two-byte registers; CONFIG ignores idx
    function automatic logic [7:0] rd_byte(input ptr_e ptr, input logic idx,
                                           input logic [11:0] shadow, input logic [7:0] cfg,
                                           input logic [15:0] tlow, input logic [15:0] thigh);
        logic [7:0] b;
        b = 8'h00;
        case (ptr)
            PTR_TEMP:   b = idx ? {shadow[3:0], 4'b0000} : shadow[11:4];
            PTR_CONFIG: b = cfg;
            PTR_TLOW:   b = idx ? tlow[7:0] : tlow[15:8];
            PTR_THIGH:  b = idx ? thigh[7:0] : thigh[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tmp10x_i2c_target_i2c_bus_sync.sv
// rtl/tmp10x_i2c_target_i2c_bus_sync.sv - 2-FF sync of SCL/SDA with edge and START/STOP pulses
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);
    logic [1:0] scl_ff_q;
    logic [1:0] sda_ff_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;

    // Reset to the idle-bus level so leaving reset never fabricates an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_ff_q   <= 2'b11;
            sda_ff_q   <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_ff_q   <= {scl_ff_q[0], scl_i};
            sda_ff_q   <= {sda_ff_q[0], sda_i};
            scl_prev_q <= scl_ff_q[1];
            sda_prev_q <= sda_ff_q[1];
        end
    end

    assign scl_s       = scl_ff_q[1];
    assign sda_o       = sda_ff_q[1];
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/tmp10x_i2c_target.sv
// rtl/tmp10x_i2c_target.sv - TMP100/TMP101 register-file I2C target; TMP10X_ALERT_EN enables the thermostat
module tmp10x_i2c_target
    import tmp10x_pkg::*;
#(
    parameter logic [6:0]  ADDRESS   = 7'h48,
    parameter logic [15:0] TLOW_RST  = 16'h4B00,
    parameter logic [15:0] THIGH_RST = 16'h5000
) (
    input  logic        Clk,
    input  logic        RST,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [11:0] Temperature,
    input  logic        TempValid,
    output logic [7:0]  Config,
    output logic        Busy,
    output logic        Alert
);
    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk_i       (Clk),
        .rst_ni      (RST),
        .scl_i       (SCL),
        .sda_i       (SDA),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  shreg_q;
    logic [6:0]  tx_q;
    logic        sda_oe_q, busy_q, rw_q, idx_q, mack_q;
    ptr_e        ptr_q;
    logic [7:0]  cfg_q, msb_q;
    logic [15:0] tlow_q, thigh_q;
    logic [11:0] temp_q, shadow_q;
    logic [7:0]  rd_b;

    always_comb rd_b = rd_byte(ptr_q, idx_q, shadow_q, cfg_q, tlow_q, thigh_q);

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            shreg_q  <= 8'h00;
            tx_q     <= 7'h00;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            rw_q     <= 1'b0;
            idx_q    <= 1'b0;
            mack_q   <= 1'b0;
            ptr_q    <= PTR_TEMP;
            cfg_q    <= 8'h00;
            msb_q    <= 8'h00;
            tlow_q   <= TLOW_RST;
            thigh_q  <= THIGH_RST;
            temp_q   <= 12'h000;
            shadow_q <= 12'h000;
        end else begin
            if (TempValid && !cfg_q[CFG_SD]) temp_q <= Temperature;

            if (start_det) begin
                state_q  <= ST_ADDR;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stop_det) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                if (scl_rise) begin
                    shreg_q <= {shreg_q[6:0], sda_s};
                    cnt_q   <= cnt_q + 4'd1;
                end
                case (state_q)
                    ST_ADDR: if (scl_fall && cnt_q == 4'd8) begin
                        if (shreg_q[7:1] == ADDRESS) begin
                            state_q  <= ST_ADDR_ACK;
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            idx_q    <= 1'b0;
                            rw_q     <= shreg_q[0];
                            if (shreg_q[0]) shadow_q <= temp_q;
                        end else begin
                            state_q <= ST_IGNORE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        cnt_q <= 4'd0;
                        if (rw_q) begin
                            state_q  <= ST_RDATA;
                            sda_oe_q <= ~rd_b[7];
                            tx_q     <= rd_b[6:0];
                        end else begin
                            state_q  <= ST_PTR;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    ST_PTR: if (scl_fall && cnt_q == 4'd8) begin
                        state_q  <= ST_PTR_ACK;
                        sda_oe_q <= 1'b1;
                        ptr_q    <= ptr_e'(shreg_q[1:0]);
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        state_q  <= ST_WDATA;
                        sda_oe_q <= 1'b0;
                        cnt_q    <= 4'd0;
                    end
                    ST_WDATA: if (scl_fall && cnt_q == 4'd8) begin
                        state_q  <= ST_WDATA_ACK;
                        sda_oe_q <= 1'b1;
                        idx_q    <= ~idx_q;
                        // Two-byte limits commit only once the LSB arrives
                        case (ptr_q)
                            PTR_CONFIG: cfg_q <= shreg_q;
                            PTR_TLOW:   if (idx_q) tlow_q  <= {msb_q, shreg_q[7:4], 4'b0000};
                                        else       msb_q   <= shreg_q;
                            PTR_THIGH:  if (idx_q) thigh_q <= {msb_q, shreg_q[7:4], 4'b0000};
                                        else       msb_q   <= shreg_q;
                            default: ;
                        endcase
                    end
                    ST_RDATA: if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_q  <= ST_MACK;
                            sda_oe_q <= 1'b0;
                            idx_q    <= ~idx_q;
                        end else begin
                            sda_oe_q <= ~tx_q[6];
                            tx_q     <= {tx_q[5:0], 1'b0};
                        end
                    end
                    ST_MACK: begin
                        if (scl_rise) mack_q <= ~sda_s;
                        if (scl_fall) begin
                            cnt_q <= 4'd0;
                            if (mack_q) begin
                                state_q  <= ST_RDATA;
                                sda_oe_q <= ~rd_b[7];
                                tx_q     <= rd_b[6:0];
                            end else begin
                                state_q <= ST_IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
    assign Config = cfg_q;
    assign Busy   = busy_q;

`ifdef TMP10X_ALERT_EN
    logic alert_act_q;

    // Comparator with hysteresis: set at/above THIGH, clear below TLOW
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            alert_act_q <= 1'b0;
        end else if ($signed(temp_q) >= $signed(thigh_q[15:4])) begin
            alert_act_q <= 1'b1;
        end else if ($signed(temp_q) < $signed(tlow_q[15:4])) begin
            alert_act_q <= 1'b0;
        end
    end

    assign Alert = cfg_q[CFG_POL] ? alert_act_q : ~alert_act_q;
`else
    assign Alert = 1'b1;
`endif

endmodule

// File: tb/tb_tmp10x_i2c_target.sv
// tb/tb_tmp10x_i2c_target.sv - scoreboard bench for tmp10x_i2c_target driving a bit-banged I2C master
module tb_tmp10x_i2c_target;
    localparam int T = 160;

    logic        Clk = 1'b0;
    logic        RST;
    logic        SCL;
    logic        m_drv;
    logic [11:0] Temperature;
    logic        TempValid;
    logic [7:0]  Config;
    logic        Busy;
    logic        Alert;
    wire         SDA;

    pullup (SDA);
    assign SDA = m_drv ? 1'b0 : 1'bz;

    always #5 Clk = ~Clk;

    tmp10x_i2c_target dut (
        .Clk         (Clk),
        .RST         (RST),
        .SCL         (SCL),
        .SDA         (SDA),
        .Temperature (Temperature),
        .TempValid   (TempValid),
        .Config      (Config),
        .Busy        (Busy),
        .Alert       (Alert)
    );

`ifdef TMP10X_ALERT_EN
    localparam bit ALERT_EN = 1'b1;
`else
    localparam bit ALERT_EN = 1'b0;
`endif

    string       name_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic expect_val(input string name, input logic [15:0] exp, input logic [15:0] act);
        name_q.push_back(name);
        exp_q.push_back(exp);
        obs_q.push_back(act);
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                string       nm;
                logic [15:0] e;
                logic [15:0] o;
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                o  = obs_q.pop_front();
                n_checks++;
                if (o === e) n_pass++;
                else $display("FAIL %s: got %h expected %h", nm, o, e);
            end
        end
    end

    task automatic bit_cycle(input logic drv_low, output logic s);
        m_drv = drv_low;
        #(T);
        SCL = 1'b1;
        #(T/2);
        s = SDA;
        #(T/2);
        SCL = 1'b0;
        #(T/4);
    endtask

    task automatic i2c_start();
        m_drv = 1'b1;
        #(T);
        SCL = 1'b0;
        #(T/4);
    endtask

    task automatic i2c_rstart();
        m_drv = 1'b0;
        #(T/2);
        SCL = 1'b1;
        #(T);
        m_drv = 1'b1;
        #(T);
        SCL = 1'b0;
        #(T/4);
    endtask

    task automatic i2c_stop();
        m_drv = 1'b1;
        #(T/2);
        SCL = 1'b1;
        #(T);
        m_drv = 1'b0;
        #(T);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
        bit_cycle(1'b0, s);
        nack = s;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b0, s);
            d = {d[6:0], s};
        end
        bit_cycle(ack, s);
    endtask

    task automatic pulse_temp(input logic [11:0] t);
        @(negedge Clk);
        Temperature = t;
        TempValid   = 1'b1;
        @(negedge Clk);
        TempValid   = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    task automatic write_cfg(input logic [7:0] v);
        logic n;
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h01, n);
        wr_byte(v, n);
        i2c_stop();
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        #(900us);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       n;
        logic       s;
        logic [7:0] d;

        RST = 1'b0; SCL = 1'b1; m_drv = 1'b0; Temperature = 12'h000; TempValid = 1'b0;
        #2;
        #100;
        RST = 1'b1;
        #100;
        expect_val("rst_config", 16'h00, {8'h00, Config});
        expect_val("rst_busy",   16'h0,  {15'h0, Busy});
        expect_val("rst_alert",  16'h1,  {15'h0, Alert});
        expect_val("rst_sda",    16'h1,  {15'h0, SDA});

        // Pointer to CONFIG, write 0x60
        i2c_start();
        wr_byte(8'h90, n); expect_val("cfg_addr_ack", 16'h0, {15'h0, n});
        expect_val("cfg_busy", 16'h1, {15'h0, Busy});
        wr_byte(8'h01, n); expect_val("cfg_ptr_ack", 16'h0, {15'h0, n});
        wr_byte(8'h60, n); expect_val("cfg_data_ack", 16'h0, {15'h0, n});
        i2c_stop();
        expect_val("cfg_value", 16'h60, {8'h00, Config});
        expect_val("cfg_busy_stop", 16'h0, {15'h0, Busy});

        // Temperature read 12'h190 -> 0x19, 0x00
        pulse_temp(12'h190);
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h00, n);
        i2c_rstart();
        wr_byte(8'h91, n); expect_val("temp_raddr_ack", 16'h0, {15'h0, n});
        rd_byte(1'b1, d);  expect_val("temp_msb", 16'h19, {8'h00, d});
        rd_byte(1'b0, d);  expect_val("temp_lsb", 16'h00, {8'h00, d});
        bit_cycle(1'b0, s); expect_val("temp_sda_released", 16'h1, {15'h0, s});
        expect_val("temp_busy_nack", 16'h0, {15'h0, Busy});
        i2c_stop();

        // THIGH write 0x55A7 then read back with wrap to MSB
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h03, n);
        wr_byte(8'h55, n); expect_val("thigh_msb_ack", 16'h0, {15'h0, n});
        wr_byte(8'hA7, n); expect_val("thigh_lsb_ack", 16'h0, {15'h0, n});
        i2c_stop();
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h03, n);
        i2c_rstart();
        wr_byte(8'h91, n);
        rd_byte(1'b1, d); expect_val("thigh_rd_msb",  16'h55, {8'h00, d});
        rd_byte(1'b1, d); expect_val("thigh_rd_lsb",  16'hA0, {8'h00, d});
        rd_byte(1'b0, d); expect_val("thigh_rd_wrap", 16'h55, {8'h00, d});
        i2c_stop();

        // TLOW reset value
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h02, n);
        i2c_rstart();
        wr_byte(8'h91, n);
        rd_byte(1'b1, d); expect_val("tlow_rd_msb", 16'h4B, {8'h00, d});
        rd_byte(1'b0, d); expect_val("tlow_rd_lsb", 16'h00, {8'h00, d});
        i2c_stop();

        // Wrong address is ignored entirely
        i2c_start();
        wr_byte(8'h92, n); expect_val("wrong_addr_nack", 16'h1, {15'h0, n});
        expect_val("wrong_busy", 16'h0, {15'h0, Busy});
        wr_byte(8'h01, n); expect_val("wrong_data_nack", 16'h1, {15'h0, n});
        i2c_stop();
        expect_val("wrong_cfg_kept", 16'h60, {8'h00, Config});
        i2c_start();
        wr_byte(8'h90, n); expect_val("after_wrong_ack", 16'h0, {15'h0, n});
        i2c_stop();

        // Reset while the target drives a 0 data bit (CONFIG MSB = 0)
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h01, n);
        i2c_rstart();
        wr_byte(8'h91, n);
        m_drv = 1'b0;
        #(T);
        SCL = 1'b1;
        #(T/2);
        expect_val("rdata_sda_driven", 16'h0, {15'h0, SDA});
        RST = 1'b0;
        #1;
        expect_val("rst_mid_sda",    16'h1,  {15'h0, SDA});
        expect_val("rst_mid_config", 16'h00, {8'h00, Config});
        expect_val("rst_mid_busy",   16'h0,  {15'h0, Busy});
        #100;
        RST = 1'b1;
        #100;
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h03, n);
        i2c_rstart();
        wr_byte(8'h91, n);
        rd_byte(1'b1, d); expect_val("rst_thigh_msb", 16'h50, {8'h00, d});
        rd_byte(1'b0, d); expect_val("rst_thigh_lsb", 16'h00, {8'h00, d});
        i2c_stop();

        // Thermostat hysteresis, polarity, and shutdown gating of TempValid
        pulse_temp(12'h500); expect_val("alert_500", ALERT_EN ? 16'h0 : 16'h1, {15'h0, Alert});
        pulse_temp(12'h4C0); expect_val("alert_4c0", ALERT_EN ? 16'h0 : 16'h1, {15'h0, Alert});
        pulse_temp(12'h4A0); expect_val("alert_4a0", 16'h1, {15'h0, Alert});
        pulse_temp(12'h500); expect_val("alert_500b", ALERT_EN ? 16'h0 : 16'h1, {15'h0, Alert});
        write_cfg(8'h04);    expect_val("alert_pol", 16'h1, {15'h0, Alert});
        write_cfg(8'h05);
        pulse_temp(12'h4A0); expect_val("alert_sd_hold", 16'h1, {15'h0, Alert});
        i2c_start();
        wr_byte(8'h90, n);
        wr_byte(8'h00, n);
        i2c_rstart();
        wr_byte(8'h91, n);
        rd_byte(1'b1, d); expect_val("sd_temp_msb", 16'h50, {8'h00, d});
        rd_byte(1'b0, d); expect_val("sd_temp_lsb", 16'h00, {8'h00, d});
        i2c_stop();

        repeat (200) begin
            if (exp_q.size() != 0) @(negedge Clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
